// File: rtl/echo_ranger.sv
// HC-SR04 ranging FSM: trigger generation, echo sync, divider-free cm count, timeout/stuck-echo supervision.
// The timeout strobe lands on edge TRIG_CYCLES+ECHO_TIMEOUT-1 after the tk rising edge; timeout wins over echo edges in the same cycle.
module echo_ranger #(
  parameter int TRIG_CYCLES   = 270,
  parameter int PERIOD_CYCLES = 1620000,
  parameter int CYCLES_PER_CM = 1574,
  parameter int ECHO_TIMEOUT  = 810000,
  parameter int MAX_CM        = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ech,
  output logic       tk,
  output logic [6:0] distance_cm,
  output logic       dist_valid,
  output logic       no_echo
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(ECHO_TIMEOUT + 1);
  localparam int SW = $clog2(CYCLES_PER_CM) + 1;

  localparam logic [PW-1:0] TRIG_LAST = PW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PER_SAT   = {PW{1'b1}};
  localparam logic [TW-1:0] TO_LAST   = TW'(ECHO_TIMEOUT - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CYCLES_PER_CM - 1);
  localparam logic [6:0]    CM_MAX    = 7'(MAX_CM);

  typedef enum logic [1:0] {
    S_TRIG      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_MEASURE   = 2'd2,
    S_HOLDOFF   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync;
  logic            r_ech_s;
  logic [PW-1:0]   r_per_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [SW-1:0]   r_sub_cnt;
  logic [6:0]      r_cm_cnt;
  logic            r_tk;
  logic [6:0]      r_distance;
  logic            r_dist_valid;
  logic            r_no_echo;
  logic            w_timeout;
  logic            w_strobe;
  logic [6:0]      w_dist_nxt;
  logic            w_no_echo_nxt;

  assign tk          = r_tk;
  assign distance_cm = r_distance;
  assign dist_valid  = r_dist_valid;
  assign no_echo     = r_no_echo;
  assign w_timeout   = (r_to_cnt == TO_LAST);

  // Two-flop echo synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 1'b0;
      r_ech_s <= 1'b0;
    end else begin
      r_sync  <= ech;
      r_ech_s <= r_sync;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_TRIG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; HOLDOFF never re-triggers while echo is still high
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TRIG: begin
        if (r_per_cnt >= TRIG_LAST) w_state_nxt = S_WAIT_RISE;
        else                        w_state_nxt = S_TRIG;
      end
      S_WAIT_RISE: begin
        if (w_timeout)    w_state_nxt = S_HOLDOFF;
        else if (r_ech_s) w_state_nxt = S_MEASURE;
        else              w_state_nxt = S_WAIT_RISE;
      end
      S_MEASURE: begin
        if (w_timeout || !r_ech_s) w_state_nxt = S_HOLDOFF;
        else                       w_state_nxt = S_MEASURE;
      end
      S_HOLDOFF: begin
        if ((r_per_cnt >= PER_LAST) && !r_ech_s) w_state_nxt = S_TRIG;
        else                                     w_state_nxt = S_HOLDOFF;
      end
      default: w_state_nxt = S_TRIG;
    endcase
  end

  // Result/strobe decode for the cycle that leaves WAIT_RISE or MEASURE
  always_comb begin
    w_strobe      = 1'b0;
    w_dist_nxt    = r_distance;
    w_no_echo_nxt = r_no_echo;
    if (((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) && w_timeout) begin
      w_strobe      = 1'b1;
      w_dist_nxt    = CM_MAX;
      w_no_echo_nxt = 1'b1;
    end else if ((r_state == S_MEASURE) && !r_ech_s) begin
      w_strobe      = 1'b1;
      w_dist_nxt    = r_cm_cnt;
      w_no_echo_nxt = 1'b0;
    end else begin
      w_strobe      = 1'b0;
      w_dist_nxt    = r_distance;
      w_no_echo_nxt = r_no_echo;
    end
  end

  // Period and timeout counters; period saturates so a stuck echo cannot wrap it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if ((r_state != S_TRIG) && (w_state_nxt == S_TRIG)) r_per_cnt <= '0;
      else if (r_per_cnt != PER_SAT)                      r_per_cnt <= r_per_cnt + 1'b1;
      else                                                r_per_cnt <= r_per_cnt;

      if (r_state == S_TRIG)                                          r_to_cnt <= '0;
      else if ((r_state == S_WAIT_RISE) || (r_state == S_MEASURE))    r_to_cnt <= r_to_cnt + 1'b1;
      else                                                            r_to_cnt <= r_to_cnt;
    end
  end

  // Echo-width counter; the rising sample seen in WAIT_RISE is counted too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_cnt <= '0;
      r_cm_cnt  <= 7'd0;
    end else if (r_state == S_TRIG) begin
      r_sub_cnt <= '0;
      r_cm_cnt  <= 7'd0;
    end else if (((r_state == S_WAIT_RISE) || (r_state == S_MEASURE)) && r_ech_s) begin
      if (r_sub_cnt == SUB_LAST) begin
        r_sub_cnt <= '0;
        r_cm_cnt  <= (r_cm_cnt >= CM_MAX) ? CM_MAX : r_cm_cnt + 7'd1;
      end else begin
        r_sub_cnt <= r_sub_cnt + 1'b1;
        r_cm_cnt  <= r_cm_cnt;
      end
    end else begin
      r_sub_cnt <= r_sub_cnt;
      r_cm_cnt  <= r_cm_cnt;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tk         <= 1'b0;
      r_distance   <= 7'd0;
      r_dist_valid <= 1'b0;
      r_no_echo    <= 1'b0;
    end else begin
      r_tk         <= (r_state == S_TRIG);
      r_distance   <= w_dist_nxt;
      r_dist_valid <= w_strobe;
      r_no_echo    <= w_no_echo_nxt;
    end
  end

endmodule
